poly_tone_pwm: RTL and testbench

- Multi-channel successor to the single-tone frequency generator.
- NUM_CH independent square-wave tone channels. Each channel has a programmable half-period threshold, volume and enable.
- Channels are mixed by volume-weighted sum and encoded onto one PWM output for the speaker amplifier.
- Sits between the song/note sequencer (register writes) and the audio pin.

---
 rtl/poly_tone_pwm.sv | 259 +++++++++++++++++++++++++
 tb/tb_poly_tone_pwm.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_tone_pwm.sv
// -----------------------------------------------------------------------------
// poly_tone_pwm
//   Multi-channel square-wave tone generator with a volume-weighted mixer and a
//   PWM encoder that drives the speaker amplifier pin.
//
//   Each channel counts 0..T and toggles its tone output on reaching T, so
//   the tone period is 2(T+1) clocks. Threshold writes land in a shadow register
//   and are picked up at the next wrap, so retuning never produces a runt
//   half-period. Enabled channels with their tone high contribute their volume
//   to the mix level. That level is scaled to the carrier width and latched at
//   the end of each carrier period.
//
//   Optional feature (macro TONE_DECAY_EN): per-channel plucked-note envelope.
//   The effective volume is reloaded on a volume write or on an enable rising
//   edge, then drops by one every DECAY_TICKS clocks and saturates at zero.
//   Without the macro the effective volume is simply the written volume.
//
// Ports
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   wr_en    in   register write strobe (one write per cycle)
//   wr_ch    in   target channel
//   wr_sel   in   0=threshold, 1=volume, 2=enable, 3=reserved (ignored)
//   wr_data  in   write data (low VOL_W bits = volume, bit 0 = enable)
//   tone     out  raw per-channel square waves (registered)
//   pwm      out  mixed PWM audio output (registered)
// -----------------------------------------------------------------------------
module poly_tone_pwm #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int VOL_W       = 4,
  parameter int PWM_W       = 8,
  parameter int DECAY_TICKS = 1000000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      wr_en,
  input  logic [$clog2(NUM_CH)-1:0] wr_ch,
  input  logic [1:0]                wr_sel,
  input  logic [CNT_W-1:0]          wr_data,
  output logic [NUM_CH-1:0]         tone,
  output logic                      pwm
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int LW   = VOL_W + CH_W;   // mix level width, wide enough for NUM_CH full-scale volumes
  localparam int SH   = PWM_W - LW;     // scale level up to carrier width

  localparam logic [1:0] SEL_THR = 2'd0;
  localparam logic [1:0] SEL_VOL = 2'd1;
  localparam logic [1:0] SEL_EN  = 2'd2;

  // Per-channel state
  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_d  [NUM_CH];
  logic [CNT_W-1:0]  thr_q  [NUM_CH];
  logic [CNT_W-1:0]  thr_d  [NUM_CH];
  logic [CNT_W-1:0]  shd_q  [NUM_CH];
  logic [CNT_W-1:0]  shd_d  [NUM_CH];
  logic [VOL_W-1:0]  vol_q  [NUM_CH];
  logic [VOL_W-1:0]  vol_d  [NUM_CH];
  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] tone_q, tone_d;

  // Write decode and effective volume
  logic [NUM_CH-1:0] hit_thr_s, hit_vol_s, hit_en_s, en_rise_s, wrap_s;
  logic [VOL_W-1:0]  vol_eff_s [NUM_CH];

  // Mixer and PWM
  logic [LW-1:0]     level_s;
  logic [PWM_W-1:0]  duty_q, duty_d;
  logic [PWM_W-1:0]  dutyl_q, dutyl_d;
  logic [PWM_W-1:0]  car_q, car_d;
  logic              pwm_q, pwm_d;

  // Decode the write strobe into per-channel register hits. With a
  // power-of-two channel count every wr_ch value names a real channel;
  // wr_sel=3 matches none of the hit terms and is dropped.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      hit_thr_s[i] = wr_en && (wr_ch == CH_W'(i)) && (wr_sel == SEL_THR);
      hit_vol_s[i] = wr_en && (wr_ch == CH_W'(i)) && (wr_sel == SEL_VOL);
      hit_en_s[i]  = wr_en && (wr_ch == CH_W'(i)) && (wr_sel == SEL_EN);
      en_rise_s[i] = hit_en_s[i] && wr_data[0] && !en_q[i];
      wrap_s[i]    = en_q[i] && (cnt_q[i] == thr_q[i]);
    end
  end

  // Channel next-state: counting/wrap first, then register writes override.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]  = cnt_q[i];
      thr_d[i]  = thr_q[i];
      shd_d[i]  = shd_q[i];
      vol_d[i]  = vol_q[i];
      en_d[i]   = en_q[i];
      tone_d[i] = tone_q[i];

      if (wrap_s[i]) begin
        cnt_d[i]  = {CNT_W{1'b0}};
        tone_d[i] = ~tone_q[i];
        thr_d[i]  = shd_q[i];
      end else if (en_q[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end

      // A disabled channel has nothing in flight, so the write goes live at
      // once; on a wrap cycle the freshly written value wins over the shadow.
      if (hit_thr_s[i]) begin
        shd_d[i] = wr_data;
        if (!en_q[i] || wrap_s[i]) begin
          thr_d[i] = wr_data;
        end else begin
          thr_d[i] = thr_d[i];
        end
      end else begin
        shd_d[i] = shd_q[i];
      end

      if (hit_vol_s[i]) begin
        vol_d[i] = wr_data[VOL_W-1:0];
      end else begin
        vol_d[i] = vol_q[i];
      end

      if (hit_en_s[i] && !wr_data[0]) begin
        en_d[i]   = 1'b0;
        tone_d[i] = 1'b0;
        cnt_d[i]  = {CNT_W{1'b0}};
        thr_d[i]  = shd_q[i];
      end else if (en_rise_s[i]) begin
        en_d[i]   = 1'b1;
        tone_d[i] = 1'b0;
        cnt_d[i]  = {CNT_W{1'b0}};
      end else begin
        en_d[i] = en_d[i];
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= {CNT_W{1'b0}};
        thr_q[i] <= {CNT_W{1'b0}};
        shd_q[i] <= {CNT_W{1'b0}};
        vol_q[i] <= {VOL_W{1'b0}};
      end
      en_q   <= {NUM_CH{1'b0}};
      tone_q <= {NUM_CH{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        thr_q[i] <= thr_d[i];
        shd_q[i] <= shd_d[i];
        vol_q[i] <= vol_d[i];
      end
      en_q   <= en_d;
      tone_q <= tone_d;
    end
  end

`ifdef TONE_DECAY_EN
  localparam int PRE_W = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;

  logic [PRE_W-1:0] pre_q  [NUM_CH];
  logic [PRE_W-1:0] pre_d  [NUM_CH];
  logic [VOL_W-1:0] veff_q [NUM_CH];
  logic [VOL_W-1:0] veff_d [NUM_CH];

  // Envelope: reload on volume write or enable rising edge, else decay.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      pre_d[i]  = pre_q[i];
      veff_d[i] = veff_q[i];
      if (hit_vol_s[i]) begin
        veff_d[i] = wr_data[VOL_W-1:0];
        pre_d[i]  = {PRE_W{1'b0}};
      end else if (en_rise_s[i]) begin
        veff_d[i] = vol_q[i];
        pre_d[i]  = {PRE_W{1'b0}};
      end else if (pre_q[i] == PRE_W'(DECAY_TICKS - 1)) begin
        pre_d[i]  = {PRE_W{1'b0}};
        veff_d[i] = (veff_q[i] == {VOL_W{1'b0}}) ? {VOL_W{1'b0}} : (veff_q[i] - VOL_W'(1));
      end else begin
        pre_d[i] = pre_q[i] + PRE_W'(1);
      end
    end
  end

  // Envelope registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        pre_q[i]  <= {PRE_W{1'b0}};
        veff_q[i] <= {VOL_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        pre_q[i]  <= pre_d[i];
        veff_q[i] <= veff_d[i];
      end
    end
  end

  // Expose the decaying volume to the mixer.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      vol_eff_s[i] = veff_q[i];
    end
  end
`else
  // Effective volume is the written volume.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      vol_eff_s[i] = vol_q[i];
    end
  end
`endif

  // Mixer level, carrier advance, end-of-period duty latch and PWM compare.
  always_comb begin
    level_s = {LW{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (tone_q[i] && en_q[i]) begin
        level_s = level_s + LW'(vol_eff_s[i]);
      end else begin
        level_s = level_s;
      end
    end
    duty_d  = PWM_W'(level_s) << SH;
    car_d   = car_q + PWM_W'(1);
    // Latch on the last carrier count so the new duty starts cleanly at 0.
    dutyl_d = (car_q == {PWM_W{1'b1}}) ? duty_q : dutyl_q;
    pwm_d   = (car_q < dutyl_q);
  end

  // Mixer and PWM registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_q  <= {PWM_W{1'b0}};
      dutyl_q <= {PWM_W{1'b0}};
      car_q   <= {PWM_W{1'b0}};
      pwm_q   <= 1'b0;
    end else begin
      duty_q  <= duty_d;
      dutyl_q <= dutyl_d;
      car_q   <= car_d;
      pwm_q   <= pwm_d;
    end
  end

  assign tone = tone_q;
  assign pwm  = pwm_q;

endmodule

// File: tb/tb_poly_tone_pwm.sv
// -----------------------------------------------------------------------------
// tb_poly_tone_pwm
//   Self-checking bench for poly_tone_pwm in its default build (NUM_CH=4,
//   PWM_W=8, no decay). The reference model tracks each channel as the
//   absolute clock edge of its next toggle. The mixer/carrier is tracked as
//   plain integers. Every clock the DUT outputs are compared to the model.
// -----------------------------------------------------------------------------
module tb_poly_tone_pwm;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [1:0]        wr_ch = 2'd0;
  logic [1:0]        wr_sel = 2'd0;
  logic [CNT_W-1:0]  wr_data = 32'd0;
  logic [NUM_CH-1:0] tone;
  logic              pwm;

  int checks = 0;
  int errors = 0;

  // Reference model state
  longint m_edge;
  longint m_next   [NUM_CH];
  longint m_shadow [NUM_CH];
  int     m_vol    [NUM_CH];
  bit     m_en     [NUM_CH];
  bit     m_tone   [NUM_CH];
  int     m_car, m_dl, m_duty;
  bit     m_pwm;

  poly_tone_pwm #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .VOL_W(4), .PWM_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_sel  (wr_sel),
    .wr_data (wr_data),
    .tone    (tone),
    .pwm     (pwm)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_edge = 0;
    m_car = 0; m_dl = 0; m_duty = 0; m_pwm = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_next[i] = 0; m_shadow[i] = 0; m_vol[i] = 0; m_en[i] = 1'b0; m_tone[i] = 1'b0;
    end
  endtask

  // Advance the model across one clock edge using the inputs present before it.
  task automatic model_step();
    int lvl;
    bit wrap;
    lvl = 0;
    for (int i = 0; i < NUM_CH; i++) if (m_tone[i]) lvl += m_vol[i];
    m_pwm  = (m_car < m_dl);
    if (m_car == 255) m_dl = m_duty;
    m_duty = lvl * 4;
    m_car  = (m_car + 1) % 256;
    m_edge++;
    for (int i = 0; i < NUM_CH; i++) begin
      wrap = m_en[i] && (m_next[i] == m_edge);
      if (wrap) begin
        m_tone[i] = ~m_tone[i];
        m_next[i] = m_edge + m_shadow[i] + 1;
      end
      if (wr_en && (int'(wr_ch) == i)) begin
        case (wr_sel)
          2'd0: begin
            m_shadow[i] = longint'(wr_data);
            if (wrap) m_next[i] = m_edge + longint'(wr_data) + 1;
          end
          2'd1: m_vol[i] = int'(wr_data[3:0]);
          2'd2: begin
            if (!wr_data[0]) begin
              m_en[i] = 1'b0; m_tone[i] = 1'b0;
            end else if (!m_en[i]) begin
              m_en[i] = 1'b1; m_tone[i] = 1'b0;
              m_next[i] = m_edge + m_shadow[i] + 1;
            end
          end
          default: ;
        endcase
      end
    end
  endtask

  function automatic logic [NUM_CH-1:0] model_tone();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i] = m_tone[i];
    return v;
  endfunction

  // One clock: step model at the edge, compare just after it.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_eq("tone", 64'(tone), 64'(model_tone()));
    check_eq("pwm", 64'(pwm), 64'(m_pwm));
  endtask

  task automatic wr(input int ch, input int sel, input logic [31:0] d);
    wr_en = 1'b1; wr_ch = 2'(ch); wr_sel = 2'(sel); wr_data = d;
    cycle();
    wr_en = 1'b0;
  endtask

  // Clocks until tone[ch] changes (-1 if it never does within the bound).
  task automatic wait_change(input int ch, output int n);
    logic prev;
    prev = tone[ch];
    n = -1;
    for (int k = 1; k <= 64; k++) begin
      cycle();
      if (tone[ch] !== prev) begin
        n = k;
        break;
      end
    end
  endtask

  // Run until the model says a carrier period with the given duty has begun.
  task automatic wait_period(input int duty, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 6000; k++) begin
      cycle();
      if (m_car == 0 && m_dl == duty) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic count_highs(output int hi);
    hi = 0;
    for (int k = 0; k < 256; k++) begin
      cycle();
      if (pwm === 1'b1) hi++;
    end
  endtask

  initial begin
    int n, hi;
    bit ok;
    int ch, sel;
    logic [31:0] d;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tone", 64'(tone), 64'd0);
    check_eq("rst_pwm", 64'(pwm), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    // Basic tone: T=3 gives half-periods of 4 clocks
    wr(0, 0, 32'd3); wr(0, 1, 32'd15); wr(0, 2, 32'd1);
    wait_change(0, n); check_eq("basic_first", 64'(n), 64'd4);
    wait_change(0, n); check_eq("basic_half", 64'(n), 64'd4);
    repeat (600) cycle();

    // Glitch-free retune on ch1
    wr(1, 0, 32'd9); wr(1, 1, 32'd5); wr(1, 2, 32'd1);
    wait_change(1, n); check_eq("retune_first", 64'(n), 64'd10);
    cycle(); cycle();
    wr(1, 0, 32'd4);
    wait_change(1, n); check_eq("retune_cur", 64'(n + 3), 64'd10);
    wait_change(1, n); check_eq("retune_new", 64'(n), 64'd5);
    // Write landing exactly on the wrap edge takes effect immediately
    repeat (4) cycle();
    wr(1, 0, 32'd7);
    wait_change(1, n); check_eq("wrap_write", 64'(n), 64'd8);

    // Disable while high, then re-enable
    if (tone[1] !== 1'b1) wait_change(1, n);
    wr(1, 2, 32'd0);
    check_eq("dis_tone", 64'(tone[1]), 64'd0);
    repeat (20) cycle();
    check_eq("dis_hold", 64'(tone[1]), 64'd0);
    wr(1, 2, 32'd1);
    wait_change(1, n); check_eq("reen_first", 64'(n), 64'd8);
    repeat (300) cycle();

    // Async reset off-edge clears outputs immediately
    if (tone == 4'd0) wait_change(0, n);
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_tone", 64'(tone), 64'd0);
    check_eq("arst_pwm", 64'(pwm), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("arst_hold", 64'(tone), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    repeat (300) cycle();

    // Full mix: all four channels at full volume
    for (int c = 0; c < NUM_CH; c++) begin
      wr(c, 0, 32'd3000); wr(c, 1, 32'd15);
    end
    for (int c = 0; c < NUM_CH; c++) wr(c, 2, 32'd1);
    wait_period(240, ok); check_eq("mix240_wait", 64'(ok), 64'd1);
    count_highs(hi); check_eq("mix240", 64'(hi), 64'd240);
    wr(2, 1, 32'd0);
    wait_period(180, ok); check_eq("mix180_wait", 64'(ok), 64'd1);
    count_highs(hi); check_eq("mix180", 64'(hi), 64'd180);

    // Randomized writes against the model
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        ch  = int'($urandom_range(0, 3));
        sel = int'($urandom_range(0, 3));
        case (sel)
          0: d = 32'($urandom_range(0, 12));
          1: d = 32'($urandom_range(0, 15));
          2: d = ($urandom_range(0, 3) != 0) ? 32'd1 : 32'd0;
          default: d = $urandom;
        endcase
        wr(ch, sel, d);
      end else begin
        cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
